// File: rtl/modular_addsub_pipe.sv
// Two-stage modular add/sub/negate/pass pipeline over LANES independent coefficient lanes.
// S1 forms the raw (DATA_WIDTH+1)-bit value per lane; S2 applies one conditional correction.
module modular_addsub_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       modulus,
  input  logic [1:0]                  op,
  input  logic [LANES*DATA_WIDTH-1:0] in1,
  input  logic [LANES*DATA_WIDTH-1:0] in2,
  input  logic [TAG_WIDTH-1:0]        in_tag,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]        out_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        range_err,
  input  logic                        clear_err
);

  localparam int EW = DATA_WIDTH + 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NEG  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  logic                  s1_valid;
  logic [1:0]            s1_op;
  logic [DATA_WIDTH-1:0] s1_q;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [LANES*EW-1:0]   s1_raw;
  logic [LANES-1:0]      s1_zero;

  logic [LANES*EW-1:0]         raw_next;
  logic [LANES-1:0]            zero_next;
  logic [LANES-1:0]            lane_err;
  logic [LANES*DATA_WIDTH-1:0] res_next;

  logic s1_load;
  logic s2_load;
  logic accept;
  logic b_checked;
  logic [EW-1:0] q_x;
  logic [EW-1:0] s1_q_x;

  // out_valid doubles as the S2 valid bit
  assign s2_load   = !out_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign accept    = in_valid && in_ready;
  assign b_checked = (op == OP_ADD) || (op == OP_SUB);
  assign q_x       = {1'b0, modulus};
  assign s1_q_x    = {1'b0, s1_q};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [EW-1:0]         a_x;
    logic [EW-1:0]         b_x;
    logic [EW-1:0]         raw;
    logic [EW-1:0]         raw_s1;
    logic [DATA_WIDTH-1:0] fixd;

    assign a_x = {1'b0, in1[i*DATA_WIDTH +: DATA_WIDTH]};
    assign b_x = {1'b0, in2[i*DATA_WIDTH +: DATA_WIDTH]};

    always_comb begin
      raw = a_x;
      case (op)
        OP_ADD:  raw = a_x + b_x;
        OP_SUB:  raw = a_x - b_x;
        OP_NEG:  raw = q_x - a_x;
        OP_PASS: raw = a_x;
        default: raw = a_x;
      endcase
    end

    assign raw_next[i*EW +: EW] = raw;
    assign zero_next[i]         = (a_x == '0);
    assign lane_err[i]          = (a_x >= q_x) || (b_checked && (b_x >= q_x));

    // Correction is done in DATA_WIDTH bits; the extra raw bit only steers the decision.
    assign raw_s1 = s1_raw[i*EW +: EW];

    always_comb begin
      fixd = raw_s1[DATA_WIDTH-1:0];
      case (s1_op)
        OP_ADD:  fixd = (raw_s1 >= s1_q_x) ? raw_s1[DATA_WIDTH-1:0] - s1_q
                                           : raw_s1[DATA_WIDTH-1:0];
        OP_SUB:  fixd = raw_s1[EW-1] ? raw_s1[DATA_WIDTH-1:0] + s1_q
                                     : raw_s1[DATA_WIDTH-1:0];
        OP_NEG:  fixd = s1_zero[i] ? '0 : raw_s1[DATA_WIDTH-1:0];
        default: fixd = raw_s1[DATA_WIDTH-1:0];
      endcase
    end

    assign res_next[i*DATA_WIDTH +: DATA_WIDTH] = fixd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_q     <= '0;
      s1_tag   <= '0;
      s1_raw   <= '0;
      s1_zero  <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_q    <= modulus;
        s1_tag  <= in_tag;
        s1_raw  <= raw_next;
        s1_zero <= zero_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_next;
        out_tag <= s1_tag;
      end
    end
  end

  // A new error wins over a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if (accept && (|lane_err)) begin
      range_err <= 1'b1;
    end else if (clear_err) begin
      range_err <= 1'b0;
    end
  end

endmodule
